// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types for the unified memory arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  localparam int BURST_CNT_W = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// rtl/arb_starve_cnt.sv - saturating count of data grants won while a fetch waits
module arb_starve_cnt #(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         inc,
  output logic                         at_max,
  output logic [arb_pkg::BURST_CNT_W-1:0] cnt
);
  import arb_pkg::*;

  logic [BURST_CNT_W-1:0] cnt_q;
  logic [BURST_CNT_W-1:0] cnt_d;

  assign at_max = (cnt_q == BURST_CNT_W'(MAX_DATA_BURST));
  assign cnt    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one single-ported memory between fetch and load/store
module unified_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack
);
  import arb_pkg::*;

  arb_state_t        state_q, state_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  arb_owner_t               winner;
  logic                     cnt_clr;
  logic                     cnt_inc;
  logic                     burst_at_max;
  logic [BURST_CNT_W-1:0]   burst_cnt;

  arb_starve_cnt #(
    .MAX_DATA_BURST(MAX_DATA_BURST)
  ) u_starve_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .at_max(burst_at_max),
    .cnt   (burst_cnt)
  );

  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    winner     = OWN_D;

    case (state_q)
      IDLE: begin
        // Data wins unless a waiting fetch has already lost MAX_DATA_BURST times.
        if (d_req && (!if_req || !burst_at_max)) begin
          winner    = OWN_D;
          cnt_inc   = if_req;
          state_d   = GRANT_D;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end else if (if_req) begin
          winner    = OWN_I;
          cnt_clr   = 1'b1;
          state_d   = GRANT_I;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = if_addr;
        end
      end
      GRANT_I: begin
        if (m_ack) begin
          m_req_d    = 1'b0;
          m_we_d     = 1'b0;
          if_rdata_d = m_rdata;
          if_ready_d = 1'b1;
          state_d    = RESP;
        end
      end
      GRANT_D: begin
        if (m_ack) begin
          m_req_d   = 1'b0;
          m_we_d    = 1'b0;
          if (!m_we_q) begin
            d_rdata_d = m_rdata;
          end
          d_ready_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_ready = if_ready_q;
  assign d_ready  = d_ready_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;

  int errors = 0;
  int checks = 0;

  int          ack_lat  = 0;
  int          wait_cnt = 0;
  logic        ack_en   = 1'b0;
  logic        ack_man  = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        both_seen = 1'b0;

  unified_mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_DATA_BURST(4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_rdata(if_rdata),
    .if_ready(if_ready),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ready (d_ready),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack)
  );

  always #5 clock = ~clock;

  // Memory model: acks ack_lat cycles after m_req rises; ack_man injects stray acks.
  assign m_ack   = ack_man | (ack_en & m_req & (wait_cnt == ack_lat));
  assign m_rdata = mem_rdata;

  always @(posedge clock) begin
    if (!m_req || m_ack) wait_cnt <= 0;
    else                 wait_cnt <= wait_cnt + 1;
  end

  always @(negedge clock) begin
    if (if_ready && d_ready) both_seen <= 1'b1;
  end

  task automatic test_reset;
    reset = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clock);
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL reset_m_req: got %b expected 0", m_req); end
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL reset_m_we: got %b expected 0", m_we); end
    checks++; if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin errors++; $display("FAIL reset_m_bus: got addr %h wdata %h expected 0", m_addr, m_wdata); end
    checks++; if (if_ready !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got if %b d %b expected 0", if_ready, d_ready); end
    checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got if %h d %h expected 0", if_rdata, d_rdata); end
    reset = 1'b0;
  endtask

  task automatic test_fetch;
    int n_if = 0, n_d = 0;
    logic seen = 0, got_we = 1'bx;
    logic [31:0] got_addr = 'x, got_rd = 'x;
    ack_en = 1; ack_lat = 1; mem_rdata = 32'h2008_0005;
    if_req = 1; if_addr = 32'h0000_3000;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (m_req && !seen) begin seen = 1; got_addr = m_addr; got_we = m_we; end
      if (d_ready) n_d++;
      if (if_ready) begin n_if++; got_rd = if_rdata; if_req = 0; end
    end
    checks++; if (got_addr !== 32'h3000) begin errors++; $display("FAIL fetch_m_addr: got %h expected 00003000", got_addr); end
    checks++; if (got_we !== 1'b0) begin errors++; $display("FAIL fetch_m_we: got %b expected 0", got_we); end
    checks++; if (n_if != 1) begin errors++; $display("FAIL fetch_ready_pulses: got %0d expected 1", n_if); end
    checks++; if (got_rd !== 32'h2008_0005) begin errors++; $display("FAIL fetch_rdata: got %h expected 20080005", got_rd); end
    checks++; if (n_d != 0) begin errors++; $display("FAIL fetch_d_ready: got %0d pulses expected 0", n_d); end
  endtask

  task automatic test_store;
    int req_cycles = 0, n_d = 0;
    logic bad = 0;
    logic [31:0] rd = 'x;
    ack_en = 1; ack_lat = 3; mem_rdata = 32'h5555_AAAA;
    d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      if (m_req) begin
        req_cycles++;
        if (m_we !== 1'b1 || m_wdata !== 32'hDEAD_BEEF || m_addr !== 32'h10) bad = 1;
      end
      if (d_ready) begin n_d++; rd = d_rdata; d_req = 0; end
    end
    d_we = 0;
    checks++; if (req_cycles != 4) begin errors++; $display("FAIL store_req_cycles: got %0d expected 4", req_cycles); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL store_bus_stable: got unstable %b expected 0", bad); end
    checks++; if (n_d != 1) begin errors++; $display("FAIL store_ready_pulses: got %0d expected 1", n_d); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL store_d_rdata: got %h expected 00000000", rd); end
  endtask

  task automatic test_back_to_back;
    int k = 0;
    logic [9:0] order = '0;
    logic cnt_bad = 0;
    ack_en = 1; ack_lat = 0;
    if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200;
    for (int i = 0; i < 80 && k < 10; i++) begin
      @(negedge clock);
      if (if_ready || d_ready) begin
        order[k] = if_ready;
        if (if_ready && dut.burst_cnt !== 4'd0) cnt_bad = 1;
        k++;
        if (k == 10) begin if_req = 0; d_req = 0; end
      end
    end
    if_req = 0; d_req = 0;
    @(negedge clock);
    checks++; if (k != 10) begin errors++; $display("FAIL b2b_grant_count: got %0d expected 10", k); end
    checks++; if (order !== 10'b10_0001_0000) begin errors++; $display("FAIL b2b_order: got %b expected 1000010000", order); end
    checks++; if (cnt_bad !== 1'b0 || dut.burst_cnt !== 4'd0) begin errors++; $display("FAIL b2b_burst_clear: got bad %b cnt %0d expected 0", cnt_bad, dut.burst_cnt); end
  endtask

  task automatic test_load_store;
    logic [31:0] rd_load = 'x, rd_store = 'x;
    logic got = 0;
    ack_en = 1; ack_lat = 1; mem_rdata = 32'h1234_5678;
    d_req = 1; d_we = 0; d_addr = 32'h20;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (d_ready) begin got = 1; rd_load = d_rdata; d_req = 0; end
    end
    @(negedge clock);
    got = 0; mem_rdata = 32'hFFFF_FFFF;
    d_req = 1; d_we = 1; d_addr = 32'h24; d_wdata = 32'hCAFE_F00D;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (d_ready) begin got = 1; rd_store = d_rdata; d_req = 0; end
    end
    d_we = 0;
    @(negedge clock);
    checks++; if (rd_load !== 32'h1234_5678) begin errors++; $display("FAIL load_rdata: got %h expected 12345678", rd_load); end
    checks++; if (rd_store !== 32'h1234_5678) begin errors++; $display("FAIL store_keeps_rdata: got %h expected 12345678", rd_store); end
  endtask

  task automatic test_reset_mid_access;
    int n_rdy = 0;
    logic granted;
    ack_en = 0;
    d_req = 1; d_we = 0; d_addr = 32'h40;
    @(negedge clock);
    granted = m_req;
    reset = 1; d_req = 0;
    @(negedge clock);
    if (if_ready || d_ready) n_rdy++;
    reset = 0; ack_man = 1;
    @(negedge clock);
    if (if_ready || d_ready) n_rdy++;
    ack_man = 0;
    checks++; if (granted !== 1'b1) begin errors++; $display("FAIL rst_mid_granted: got m_req %b expected 1", granted); end
    checks++; if (m_req !== 1'b0 || m_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_m_bus: got m_req %b addr %h expected 0", m_req, m_addr); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_d_rdata: got %h expected 00000000", d_rdata); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (if_ready || d_ready || m_req) n_rdy++;
    end
    checks++; if (n_rdy != 0) begin errors++; $display("FAIL rst_mid_no_ready: got %0d events expected 0", n_rdy); end
  endtask

  task automatic test_stray_ack;
    int n_ev = 0;
    ack_man = 1;
    @(negedge clock);
    ack_man = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (if_ready || d_ready || m_req) n_ev++;
    end
    checks++; if (n_ev != 0) begin errors++; $display("FAIL stray_ack: got %0d events expected 0", n_ev); end
  endtask

  task automatic test_req_dropped;
    int n_if = 0;
    logic [31:0] rd = 'x;
    ack_en = 1; ack_lat = 2; mem_rdata = 32'h0000_A5A5;
    if_req = 1; if_addr = 32'h44;
    @(negedge clock);
    if_req = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (if_ready) begin n_if++; rd = if_rdata; end
    end
    checks++; if (n_if != 1) begin errors++; $display("FAIL drop_req_ready: got %0d expected 1", n_if); end
    checks++; if (rd !== 32'h0000_A5A5) begin errors++; $display("FAIL drop_req_rdata: got %h expected 0000a5a5", rd); end
  endtask

  task automatic test_ready_exclusive;
    checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL ready_exclusive: got both-high %b expected 0", both_seen); end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_store;
    test_back_to_back;
    test_load_store;
    test_reset_mid_access;
    test_stray_ack;
    test_req_dropped;
    test_ready_exclusive;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
